hmem_ctrl: RTL and testbench

//  Line-granular memory controller directly downstream of the hart's h_* memory bus.

---
 rtl/hmem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hmem_ctrl.sv | 541 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmem_ctrl.sv
// hmem_ctrl: splits LINE_W hart line reads/writes into BEAT_W req/ack beats
// and arbitrates the hart AMO lock. Ports: h_* hart line bus and AMO
// handshake, h_inv/h_inv_addr line invalidate, m_* beat port.
// Optional feature: HMEM_INV_EN enables the write-invalidate pulse.
module hmem_ctrl #(
  parameter int          LINE_W   = 256,
  parameter int          BEAT_W   = 64,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0001_0000
) (
  input  logic              h_clk,
  input  logic              h_rst_n,
  input  logic [63:0]       h_addr,
  input  logic              h_rd,
  input  logic              h_wr,
  input  logic [LINE_W-1:0] h_data_out,
  output logic [LINE_W-1:0] h_data_in,
  output logic              h_dv,
  input  logic              h_amo_req,
  output logic              h_amo_ack,
  output logic [63:0]       h_inv_addr,
  output logic              h_inv,
  output logic [63:0]       m_addr,
  output logic              m_req,
  output logic              m_we,
  output logic [BEAT_W-1:0] m_wdata,
  input  logic [BEAT_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam int N  = LINE_W / BEAT_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [63:0] LMASK = 64'(LINE_W / 8 - 1);
  localparam logic [63:0] BSTEP = 64'(BEAT_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DONE,
    RELEASE
  } state_t;

  state_t            state;
  logic [63:0]       lbase;
  logic [LINE_W-1:0] wbuf;
  logic [LINE_W-1:0] rbuf;
  logic [LINE_W-1:0] merged;
  logic              dir;
  logic [IW-1:0]     idx;

  logic [63:0] abase;
  logic        in_range;
  logic        last;
  logic        beat_done;
  logic        amo_grant;

  assign abase     = h_addr & ~LMASK;
  assign in_range  = (abase >= MEM_BASE) &&
                     ((abase - MEM_BASE) < MEM_SIZE);
  assign last      = (idx == IW'(N - 1));
  assign beat_done = (state == BEAT) && m_req && m_ack;

  // DONE grants a lock requested mid-transaction; idle points
  // grant only when no strobe is waiting to be serviced.
  assign amo_grant = (state == DONE) ||
                     (((state == IDLE) || (state == RELEASE)) &&
                      !h_rd && !h_wr);

  // read line with the beat currently being acked merged in
  always_comb begin
    merged = rbuf;
    merged[int'(idx)*BEAT_W +: BEAT_W] = m_rdata;
  end

  always_ff @(posedge h_clk) begin
    if (!h_rst_n) begin
      state     <= IDLE;
      lbase     <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      dir       <= 1'b0;
      idx       <= '0;
      h_data_in <= '0;
      h_dv      <= 1'b0;
      h_amo_ack <= 1'b0;
      m_addr    <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_wdata   <= '0;
    end else begin
      h_dv <= 1'b0;
      if (!h_amo_req)
        h_amo_ack <= 1'b0;
      else if (amo_grant)
        h_amo_ack <= 1'b1;
      unique case (state)
        IDLE: begin
          if (h_wr || h_rd) begin
            dir   <= h_wr;
            lbase <= abase;
            wbuf  <= h_data_out;
            idx   <= '0;
            if (in_range) begin
              state   <= BEAT;
              m_req   <= 1'b1;
              m_we    <= h_wr;
              m_addr  <= abase;
              m_wdata <= h_wr ? h_data_out[BEAT_W-1:0] : '0;
            end else begin
              state <= DONE;
              h_dv  <= 1'b1;
              if (!h_wr)
                h_data_in <= '0;
            end
          end
        end
        BEAT: begin
          if (m_req) begin
            if (m_ack) begin
              m_req <= 1'b0;
              m_we  <= 1'b0;
              if (!dir)
                rbuf <= merged;
              if (last) begin
                state <= DONE;
                h_dv  <= 1'b1;
                if (!dir)
                  h_data_in <= merged;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end else begin
            // gap cycle over: issue the next beat
            m_req   <= 1'b1;
            m_we    <= dir;
            m_addr  <= lbase + 64'(idx) * BSTEP;
            m_wdata <= dir ? wbuf[int'(idx)*BEAT_W +: BEAT_W] : '0;
          end
        end
        DONE: begin
          state <= RELEASE;
        end
        RELEASE: begin
          // hold until the serviced level drops
          if (dir ? !h_wr : !h_rd)
            state <= IDLE;
        end
      endcase
    end
  end

`ifdef HMEM_INV_EN
  logic inv_set;

  assign inv_set = beat_done && last && dir;

  always_ff @(posedge h_clk) begin
    if (!h_rst_n) begin
      h_inv      <= 1'b0;
      h_inv_addr <= '0;
    end else begin
      h_inv <= inv_set;
      if (inv_set)
        h_inv_addr <= lbase;
    end
  end
`else
  assign h_inv      = 1'b0;
  assign h_inv_addr = '0;
`endif

endmodule

// File: tb/tb_hmem_ctrl.sv
// tb_hmem_ctrl: scoreboard bench for hmem_ctrl with a 2-cycle
// req/ack backing memory responder.
module tb_hmem_ctrl;

  localparam logic [63:0] BASE = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } beat_t;

  logic         h_clk = 1'b0;
  logic         h_rst_n = 1'b0;
  logic [63:0]  h_addr = '0;
  logic         h_rd = 1'b0;
  logic         h_wr = 1'b0;
  logic [255:0] h_data_out = '0;
  logic [255:0] h_data_in;
  logic         h_dv;
  logic         h_amo_req = 1'b0;
  logic         h_amo_ack;
  logic [63:0]  h_inv_addr;
  logic         h_inv;
  logic [63:0]  m_addr;
  logic         m_req;
  logic         m_we;
  logic [63:0]  m_wdata;
  logic [63:0]  m_rdata = '0;
  logic         m_ack = 1'b0;

  hmem_ctrl dut (
    .h_clk      (h_clk),
    .h_rst_n    (h_rst_n),
    .h_addr     (h_addr),
    .h_rd       (h_rd),
    .h_wr       (h_wr),
    .h_data_out (h_data_out),
    .h_data_in  (h_data_in),
    .h_dv       (h_dv),
    .h_amo_req  (h_amo_req),
    .h_amo_ack  (h_amo_ack),
    .h_inv_addr (h_inv_addr),
    .h_inv      (h_inv),
    .m_addr     (m_addr),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ack      (m_ack)
  );

  always #5 h_clk = ~h_clk;

  logic [63:0]  mem [8192];
  beat_t        exp_q[$];
  beat_t        obs_q[$];
  logic [255:0] line_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           dv_cnt = 0;
  int           req_cnt = 0;
  int           inv_cnt = 0;
  int           wcnt = 0;
  logic [63:0]  inv_seen = '0;
  logic         prev_req = 1'b0;
  logic [255:0] last_rd = '0;

  function automatic int mix(input logic [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  // monitor + backing memory: ack 2 cycles after each m_req
  always @(negedge h_clk) begin
    if (m_req && !prev_req) begin
      obs_q.push_back({m_addr, m_we, m_wdata});
      req_cnt++;
    end
    prev_req = m_req;
    if (h_dv) dv_cnt++;
    if (h_inv) begin
      inv_cnt++;
      inv_seen = h_inv_addr;
    end
    if (m_ack) begin
      m_ack = 1'b0;
    end else if (m_req) begin
      wcnt++;
      if (wcnt == 2) begin
        wcnt = 0;
        m_ack = 1'b1;
        if (m_we) mem[mix(m_addr)] = m_wdata;
        else m_rdata = mem[mix(m_addr)];
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic wait_dv(output int lat);
    lat = -1;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(negedge h_clk);
      if (h_dv === 1'b1) lat = k;
    end
  endtask

  task automatic test_reset();
    h_rst_n = 1'b0;
    repeat (3) @(posedge h_clk);
    #1;
    n_chk++;
    if ({h_dv, h_amo_ack, h_inv, m_req, m_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {h_dv, h_amo_ack, h_inv, m_req, m_we});
    end
    n_chk++;
    if ({h_data_in, h_inv_addr, m_addr, m_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 0",
               {h_data_in, h_inv_addr, m_addr, m_wdata});
    end
    h_rst_n = 1'b1;
  endtask

  task automatic test_read();
    logic [255:0] ln;
    beat_t e, o;
    int lat, d0, r0;
    for (int i = 0; i < 4; i++)
      mem[8+i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({BASE + 64'h40 + 64'(8 * i), 1'b0, 64'h0});
    line_q.push_back({mem[11], mem[10], mem[9], mem[8]});
    repeat (3) @(posedge h_clk);
    #1;
    d0 = dv_cnt;
    r0 = req_cnt;
    h_addr = BASE + 64'h44;
    h_rd = 1'b1;
    wait_dv(lat);
    n_chk++;
    if (lat != 13) begin
      n_fail++;
      $display("FAIL read_latency got %0d exp 13", lat);
    end
    ln = line_q.pop_front();
    n_chk++;
    if (h_data_in !== ln) begin
      n_fail++;
      $display("FAIL read_line got %h exp %h", h_data_in, ln);
    end
    last_rd = ln;
    repeat (10) @(negedge h_clk);
    n_chk++;
    if (req_cnt != r0 + 4 || dv_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL read_held got req %0d dv %0d exp 4 1",
               req_cnt - r0, dv_cnt - d0);
    end
    h_rd = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_beat missing exp %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.we !== e.we) begin
          n_fail++;
          $display("FAIL read_beat got %h/%b exp %h/%b",
                   o.addr, o.we, e.addr, e.we);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_extra got %0d beats exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_write_read();
    logic [255:0] wl, ln;
    beat_t e, o;
    int lat;
    for (int i = 0; i < 4; i++)
      wl[64*i +: 64] = 64'hDEAD_BEEF_0000_0000 + 64'(i);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({BASE + 64'h100 + 64'(8 * i), 1'b1, wl[64*i +: 64]});
    for (int i = 0; i < 4; i++)
      exp_q.push_back({BASE + 64'h100 + 64'(8 * i), 1'b0, 64'h0});
    line_q.push_back(wl);
    inv_cnt = 0;
    repeat (3) @(posedge h_clk);
    #1;
    h_addr = BASE + 64'h100;
    h_data_out = wl;
    h_wr = 1'b1;
    wait_dv(lat);
    n_chk++;
    if (lat != 13) begin
      n_fail++;
      $display("FAIL write_latency got %0d exp 13", lat);
    end
    n_chk++;
    if (h_data_in !== last_rd) begin
      n_fail++;
      $display("FAIL write_keeps_rd got %h exp %h", h_data_in, last_rd);
    end
`ifdef HMEM_INV_EN
    n_chk++;
    if (h_inv !== 1'b1 || h_inv_addr !== BASE + 64'h100) begin
      n_fail++;
      $display("FAIL write_inv got %b %h exp 1 %h",
               h_inv, h_inv_addr, BASE + 64'h100);
    end
`else
    n_chk++;
    if (h_inv !== 1'b0 || h_inv_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL write_inv got %b %h exp 0 0", h_inv, h_inv_addr);
    end
`endif
    h_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (mem[32+i] !== wl[64*i +: 64]) begin
        n_fail++;
        $display("FAIL write_mem%0d got %h exp %h",
                 i, mem[32+i], wl[64*i +: 64]);
      end
    end
    repeat (3) @(posedge h_clk);
    #1;
    h_rd = 1'b1;
    wait_dv(lat);
    ln = line_q.pop_front();
    n_chk++;
    if (lat != 13 || h_data_in !== ln) begin
      n_fail++;
      $display("FAIL readback got %h lat %0d exp %h lat 13",
               h_data_in, lat, ln);
    end
    h_rd = 1'b0;
    n_chk++;
`ifdef HMEM_INV_EN
    if (inv_cnt != 1 || inv_seen !== BASE + 64'h100) begin
      n_fail++;
      $display("FAIL inv_count got %0d %h exp 1 %h",
               inv_cnt, inv_seen, BASE + 64'h100);
    end
`else
    if (inv_cnt != 0) begin
      n_fail++;
      $display("FAIL inv_count got %0d exp 0", inv_cnt);
    end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_beat missing exp %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.we !== e.we ||
            (e.we && o.wdata !== e.wdata)) begin
          n_fail++;
          $display("FAIL wr_beat got %h/%b/%h exp %h/%b/%h",
                   o.addr, o.we, o.wdata, e.addr, e.we, e.wdata);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL wr_extra got %0d beats exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_out_of_range();
    int lat, r0, i0;
    r0 = req_cnt;
    i0 = inv_cnt;
    repeat (3) @(posedge h_clk);
    #1;
    h_addr = 64'h0000_1000;
    h_rd = 1'b1;
    wait_dv(lat);
    n_chk++;
    if (lat != 2 || h_data_in !== 256'h0) begin
      n_fail++;
      $display("FAIL oob_read got lat %0d line %h exp 2 0", lat, h_data_in);
    end
    h_rd = 1'b0;
    repeat (3) @(posedge h_clk);
    #1;
    h_addr = BASE + 64'h0001_0000;
    h_data_out = {4{64'h5A5A_5A5A_5A5A_5A5A}};
    h_wr = 1'b1;
    wait_dv(lat);
    n_chk++;
    if (lat != 2 || h_data_in !== 256'h0) begin
      n_fail++;
      $display("FAIL oob_write got lat %0d line %h exp 2 0", lat, h_data_in);
    end
    h_wr = 1'b0;
    repeat (3) @(negedge h_clk);
    n_chk++;
    if (req_cnt != r0 || inv_cnt != i0) begin
      n_fail++;
      $display("FAIL oob_noreq got req %0d inv %0d exp 0 0",
               req_cnt - r0, inv_cnt - i0);
    end
  endtask

  task automatic test_both();
    logic [255:0] bl, ln;
    beat_t e, o;
    int lat, d0, r0;
    for (int i = 0; i < 4; i++)
      bl[64*i +: 64] = 64'hC0DE_0000_0000_0200 + 64'(i << 4);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({BASE + 64'h200 + 64'(8 * i), 1'b1, bl[64*i +: 64]});
    for (int i = 0; i < 4; i++)
      exp_q.push_back({BASE + 64'h200 + 64'(8 * i), 1'b0, 64'h0});
    line_q.push_back(bl);
    repeat (3) @(posedge h_clk);
    #1;
    d0 = dv_cnt;
    h_addr = BASE + 64'h200;
    h_data_out = bl;
    h_rd = 1'b1;
    h_wr = 1'b1;
    wait_dv(lat);
    n_chk++;
    if (lat != 13) begin
      n_fail++;
      $display("FAIL both_first got lat %0d exp 13", lat);
    end
    h_wr = 1'b0;
    wait_dv(lat);
    ln = line_q.pop_front();
    n_chk++;
    if (lat < 0 || h_data_in !== ln) begin
      n_fail++;
      $display("FAIL both_read got %h lat %0d exp %h", h_data_in, lat, ln);
    end
    r0 = req_cnt;
    repeat (10) @(negedge h_clk);
    n_chk++;
    if (req_cnt != r0 || dv_cnt != d0 + 2) begin
      n_fail++;
      $display("FAIL both_held got req %0d dv %0d exp 0 2",
               req_cnt - r0, dv_cnt - d0);
    end
    h_rd = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL both_beat missing exp %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.we !== e.we ||
            (e.we && o.wdata !== e.wdata)) begin
          n_fail++;
          $display("FAIL both_beat got %h/%b/%h exp %h/%b/%h",
                   o.addr, o.we, o.wdata, e.addr, e.we, e.wdata);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL both_extra got %0d beats exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_amo();
    logic [255:0] ln;
    int lat, r0;
    line_q.push_back({mem[11], mem[10], mem[9], mem[8]});
    repeat (3) @(posedge h_clk);
    #1;
    r0 = req_cnt;
    h_addr = BASE + 64'h40;
    h_rd = 1'b1;
    for (int k = 0; k < 100 && req_cnt < r0 + 3; k++) begin
      @(negedge h_clk);
      #1;
    end
    n_chk++;
    if (req_cnt != r0 + 3) begin
      n_fail++;
      $display("FAIL amo_beat2 got %0d beats exp 3", req_cnt - r0);
    end
    h_amo_req = 1'b1;
    wait_dv(lat);
    ln = line_q.pop_front();
    n_chk++;
    if (lat < 0 || h_amo_ack !== 1'b0 || h_data_in !== ln) begin
      n_fail++;
      $display("FAIL amo_dv got ack %b lat %0d line %h exp 0 %h",
               h_amo_ack, lat, h_data_in, ln);
    end
    h_rd = 1'b0;
    @(negedge h_clk);
    n_chk++;
    if (h_amo_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL amo_grant got %b exp 1", h_amo_ack);
    end
    @(posedge h_clk);
    #1;
    h_amo_req = 1'b0;
    @(negedge h_clk);
    n_chk++;
    if (h_amo_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL amo_hold got %b exp 1", h_amo_ack);
    end
    @(negedge h_clk);
    n_chk++;
    if (h_amo_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL amo_drop got %b exp 0", h_amo_ack);
    end
    repeat (3) @(posedge h_clk);
    #1;
    h_amo_req = 1'b1;
    @(negedge h_clk);
    n_chk++;
    if (h_amo_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL amo_idle_early got %b exp 0", h_amo_ack);
    end
    @(negedge h_clk);
    n_chk++;
    if (h_amo_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL amo_idle_grant got %b exp 1", h_amo_ack);
    end
    h_amo_req = 1'b0;
    repeat (2) @(negedge h_clk);
    n_chk++;
    if (obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL amo_beats got %0d exp 4", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_write();
    logic [255:0] nl, ln;
    int lat, d0, r0;
    for (int i = 0; i < 4; i++) begin
      mem[96+i] = 64'h0123_4567_89AB_CDE0 + 64'(i);
      nl[64*i +: 64] = 64'hFEED_0000_0000_0000 + 64'(i);
    end
    repeat (3) @(posedge h_clk);
    #1;
    d0 = dv_cnt;
    r0 = req_cnt;
    h_addr = BASE + 64'h300;
    h_data_out = nl;
    h_wr = 1'b1;
    for (int k = 0; k < 100 && req_cnt < r0 + 3; k++) begin
      @(negedge h_clk);
      #1;
    end
    h_rst_n = 1'b0;
    @(negedge h_clk);
    n_chk++;
    if (m_req !== 1'b0 || h_dv !== 1'b0 || req_cnt != r0 + 3) begin
      n_fail++;
      $display("FAIL rst_mid got req %b dv %b beats %0d exp 0 0 3",
               m_req, h_dv, req_cnt - r0);
    end
    h_wr = 1'b0;
    @(posedge h_clk);
    #1;
    h_rst_n = 1'b1;
    repeat (5) @(negedge h_clk);
    n_chk++;
    if (dv_cnt != d0) begin
      n_fail++;
      $display("FAIL rst_nodv got %0d dv exp 0", dv_cnt - d0);
    end
    ln = {mem[99], mem[98], nl[127:0]};
    n_chk++;
    if (mem[98] !== 64'h0123_4567_89AB_CDE2 ||
        mem[99] !== 64'h0123_4567_89AB_CDE3 ||
        mem[96] !== nl[63:0] || mem[97] !== nl[127:64]) begin
      n_fail++;
      $display("FAIL rst_mem got %h %h %h %h",
               mem[99], mem[98], mem[97], mem[96]);
    end
    obs_q.delete();
    repeat (2) @(posedge h_clk);
    #1;
    h_rd = 1'b1;
    wait_dv(lat);
    n_chk++;
    if (lat != 13 || h_data_in !== ln) begin
      n_fail++;
      $display("FAIL rst_readback got %h lat %0d exp %h lat 13",
               h_data_in, lat, ln);
    end
    h_rd = 1'b0;
    repeat (3) @(posedge h_clk);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    test_reset();
    test_read();
    test_write_read();
    test_out_of_range();
    test_both();
    test_amo();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
